// File: rtl/ext_async_bus_ctrl.sv
// CPU-to-asynchronous peripheral bus bridge: programmable setup/strobe/hold, word packing, peripheral reset pulse, irq sync.
// Optional ready-wait with timeout enabled by defining EXT_BUS_READY_EN.
module ext_async_bus_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 1,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_op,
  input  logic              write_op,
  input  logic              bus_size,
  input  logic [31:0]       bus_data_addr,
  input  logic [31:0]       bus_data_write,
  output logic [31:0]       bus_data_read,
  output logic              bus_stall,
  output logic              bus_error,
  output logic              irq,
  output logic [ADDR_W-1:0] ext_addr,
  inout  wire  [DATA_W-1:0] ext_d,
  output logic              ext_cs_n,
  output logic              ext_rd_n,
  output logic              ext_wr_n,
  output logic              ext_rst_n,
  input  logic              ext_intrq,
  input  logic              ext_ready_n
);

  localparam int NB = 32 / DATA_W;
  localparam int CW = 10;
  localparam int RW = (RST_CYC > 0) ? $clog2(RST_CYC + 1) : 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [1:0]    BEAT_LAST   = 2'(NB - 1);
`ifdef EXT_BUS_READY_EN
  localparam logic [CW-1:0] TOUT_LAST   = CW'(STROBE_CYC - 1 + TIMEOUT_CYC);
`endif

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          beat_q, beat_d;
  logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
  logic                is_rd_q, is_rd_d, size_q, size_d, tout_q, tout_d;
  logic                cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                drive_q, drive_d, stall_q, stall_d, err_q, err_d;
  logic                ext_rst_n_q, ext_rst_n_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sync_q;
  logic                strobe_done, timed_out;
  logic [DATA_W-1:0]   cap;
  logic [1:0]          next_beat;
  logic                unused_inputs;

  assign unused_inputs = ^{bus_data_addr[31:ADDR_W+2], bus_data_addr[1:0], ext_ready_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      rst_cnt_q   <= RW'(RST_CYC);
      is_rd_q     <= 1'b0;
      size_q      <= 1'b0;
      tout_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      stall_q     <= (RST_CYC != 0);
      err_q       <= 1'b0;
      ext_rst_n_q <= (RST_CYC == 0);
      dout_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      rst_cnt_q   <= rst_cnt_d;
      is_rd_q     <= is_rd_d;
      size_q      <= size_d;
      tout_q      <= tout_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      drive_q     <= drive_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      ext_rst_n_q <= ext_rst_n_d;
      dout_q      <= dout_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      sync_q      <= {sync_q[0], ext_intrq};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    rst_cnt_d   = rst_cnt_q;
    is_rd_d     = is_rd_q;
    size_d      = size_q;
    tout_d      = tout_q;
    cs_n_d      = cs_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    drive_d     = drive_q;
    stall_d     = stall_q;
    err_d       = 1'b0;
    ext_rst_n_d = ext_rst_n_q;
    dout_d      = dout_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    strobe_done = 1'b0;
    timed_out   = 1'b0;
    next_beat   = beat_q + 2'd1;
`ifdef EXT_BUS_READY_EN
    if (cnt_q >= STROBE_LAST) begin
      if (!ext_ready_n) begin
        strobe_done = 1'b1;
      end else if (cnt_q == TOUT_LAST) begin
        strobe_done = 1'b1;
        timed_out   = 1'b1;
      end
    end
`else
    strobe_done = (cnt_q == STROBE_LAST);
`endif
    cap = timed_out ? '0 : ext_d;

    case (state_q)
      IDLE: begin
        if (rst_cnt_q != '0) begin
          rst_cnt_d = rst_cnt_q - 1'b1;
          if (rst_cnt_q == RW'(1)) begin
            ext_rst_n_d = 1'b1;
            stall_d     = 1'b0;
          end
        end else if (read_op || write_op) begin
          is_rd_d = read_op;
          size_d  = bus_size;
          wdata_d = bus_data_write;
          addr_d  = bus_data_addr[ADDR_W+1:2];
          stall_d = 1'b1;
          beat_d  = '0;
          cnt_d   = '0;
          tout_d  = 1'b0;
          cs_n_d  = 1'b0;
          // Clearing on read start keeps skipped lanes of an aborted burst at zero.
          if (read_op) begin
            rdata_d = '0;
          end else begin
            drive_d = 1'b1;
            dout_d  = bus_data_write[DATA_W-1:0];
          end
          if (SETUP_CYC == 0) begin
            state_d = STROBE;
            rd_n_d  = !read_op;
            wr_n_d  = read_op;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
          rd_n_d  = !is_rd_q;
          wr_n_d  = is_rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (strobe_done) begin
          state_d = HOLD;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          tout_d  = timed_out;
          if (is_rd_q) begin
            if (size_q) rdata_d[beat_q*DATA_W +: DATA_W] = cap;
            else        rdata_d = {NB{cap}};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (!tout_q && size_q && beat_q != BEAT_LAST) begin
            beat_d = next_beat;
            cs_n_d = 1'b0;
            if (!is_rd_q) dout_d = wdata_q[next_beat*DATA_W +: DATA_W];
            if (SETUP_CYC == 0) begin
              state_d = STROBE;
              rd_n_d  = !is_rd_q;
              wr_n_d  = is_rd_q;
            end else begin
              state_d = SETUP;
            end
          end else begin
            state_d = IDLE;
            drive_d = 1'b0;
            stall_d = 1'b0;
            err_d   = tout_q;
            tout_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ext_d         = drive_q ? dout_q : {DATA_W{1'bz}};
  assign bus_data_read = rdata_q;
  assign bus_stall     = stall_q;
  assign bus_error     = err_q;
  assign irq           = sync_q[1];
  assign ext_addr      = addr_q;
  assign ext_cs_n      = cs_n_q;
  assign ext_rd_n      = rd_n_q;
  assign ext_wr_n      = wr_n_q;
  assign ext_rst_n     = ext_rst_n_q;

endmodule

// File: tb/tb_ext_async_bus_ctrl.sv
// Scoreboard bench for ext_async_bus_ctrl: expected beats/read words queued at stimulus, compared as the bus produces them.
module tb_ext_async_bus_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_op, write_op, bus_size;
  logic [31:0]   bus_data_addr, bus_data_write;
  logic [31:0]   bus_data_read;
  logic          bus_stall, bus_error, irq;
  logic [0:0]    ext_addr;
  wire  [DW-1:0] ext_d;
  logic          ext_cs_n, ext_rd_n, ext_wr_n, ext_rst_n;
  logic          ext_intrq, ext_ready_n;

  logic [DW-1:0] periph_d;
  logic [DW-1:0] rd_vals[$];
  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cs_lo, wr_lo, rd_lo, st_hi, err_hi, d_hits, addr_bad, rd_idx;

  always #5 clk = ~clk;

  assign ext_d = ext_rd_n ? {DW{1'bz}} : periph_d;

  ext_async_bus_ctrl #(.DATA_W(8), .ADDR_W(1), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1),
                       .RST_CYC(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .read_op(read_op), .write_op(write_op), .bus_size(bus_size),
    .bus_data_addr(bus_data_addr), .bus_data_write(bus_data_write), .bus_data_read(bus_data_read),
    .bus_stall(bus_stall), .bus_error(bus_error), .irq(irq), .ext_addr(ext_addr), .ext_d(ext_d),
    .ext_cs_n(ext_cs_n), .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n), .ext_rst_n(ext_rst_n),
    .ext_intrq(ext_intrq), .ext_ready_n(ext_ready_n)
  );

  // Collects per-cycle bus activity after the accept edge; comparisons live in the tests.
  task automatic observe(input int ncyc, input bit hold, input logic [0:0] exp_addr, input logic [DW-1:0] dval);
    logic prev_wr, prev_rd;
    cs_lo = 0; wr_lo = 0; rd_lo = 0; st_hi = 0; err_hi = 0; d_hits = 0; addr_bad = 0; rd_idx = 0;
    got_q.delete();
    periph_d = (rd_vals.size() > 0) ? rd_vals[0] : '0;
    @(posedge clk); #1;
    if (!hold) begin read_op = 1'b0; write_op = 1'b0; end
    prev_wr = 1'b1; prev_rd = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      if (!ext_cs_n) cs_lo++;
      if (!ext_wr_n) wr_lo++;
      if (!ext_rd_n) rd_lo++;
      if (bus_stall) st_hi++;
      if (bus_error) err_hi++;
      if (ext_d == dval) d_hits++;
      if (!ext_cs_n && ext_addr != exp_addr) addr_bad++;
      if (!ext_wr_n && prev_wr) got_q.push_back(32'(ext_d));
      if (ext_rd_n && !prev_rd) begin
        rd_idx++;
        periph_d = (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : '0;
      end
      prev_wr = ext_wr_n; prev_rd = ext_rd_n;
    end
  endtask

  task automatic test_reset();
    int n, cs_seen, stall_early;
    @(negedge clk);
    checks++;
    if (ext_cs_n !== 1'b1 || ext_rd_n !== 1'b1 || ext_wr_n !== 1'b1 || ext_rst_n !== 1'b0 ||
        bus_stall !== 1'b1 || bus_data_read !== 32'h0 || bus_error !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got cs%b rd%b wr%b rstn%b stall%b rdata%h err%b irq%b want 1 1 1 0 1 0 0 0",
               ext_cs_n, ext_rd_n, ext_wr_n, ext_rst_n, bus_stall, bus_data_read, bus_error, irq);
    end
    read_op = 1'b1; bus_data_addr = 32'h0; bus_size = 1'b0;
    rst = 1'b0;
    n = 0; cs_seen = 0; stall_early = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!ext_cs_n) cs_seen++;
      if (ext_rst_n) break;
      if (!bus_stall) stall_early++;
    end
    read_op = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL rst_pulse_len got %0d want 16", n); end
    checks++;
    if (bus_stall !== 1'b0 || stall_early !== 0) begin
      errors++; $display("FAIL rst_stall got stall=%b early_low=%0d want 0 0", bus_stall, stall_early);
    end
    @(negedge clk);
    checks++;
    if (cs_seen !== 0 || ext_cs_n !== 1'b1) begin
      errors++; $display("FAIL rst_req_ignored got cs_low=%0d cs_n=%b want 0 1", cs_seen, ext_cs_n);
    end
    $display("reset release: ext_rst_n high after %0d cycles", n);
  endtask

  task automatic test_write_single();
    @(negedge clk);
    write_op = 1'b1; bus_size = 1'b0; bus_data_addr = 32'h4; bus_data_write = 32'h0000_00A5;
    exp_q.push_back(32'hA5);
    observe(8, 1'b0, 1'b1, 8'hA5);
    checks++;
    if (cs_lo !== 3 || wr_lo !== 2) begin
      errors++; $display("FAIL wr1_strobes got cs=%0d wr=%0d want 3 2", cs_lo, wr_lo);
    end
    checks++;
    if (d_hits !== 4 || st_hi !== 4) begin
      errors++; $display("FAIL wr1_data_stall got d=%0d stall=%0d want 4 4", d_hits, st_hi);
    end
    checks++;
    if (addr_bad !== 0) begin errors++; $display("FAIL wr1_addr got bad=%0d want 0", addr_bad); end
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL wr1_beat got n=%0d v=%h want 1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 32'hx, exp_q[0]);
    end
    void'(exp_q.pop_front());
    $display("single write: ext_addr=%b cs=%0d wr=%0d stall=%0d", ext_addr, cs_lo, wr_lo, st_hi);
  endtask

  task automatic test_read_single();
    logic [31:0] e;
    @(negedge clk);
    read_op = 1'b1; bus_size = 1'b0; bus_data_addr = 32'h0;
    rd_vals = '{8'h3C};
    exp_q.push_back(32'h3C3C_3C3C);
    observe(8, 1'b0, 1'b0, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (bus_data_read !== e) begin errors++; $display("FAIL rd1_data got %h want %h", bus_data_read, e); end
    checks++;
    if (st_hi !== 4 || rd_lo !== 2 || cs_lo !== 3) begin
      errors++; $display("FAIL rd1_timing got stall=%0d rd=%0d cs=%0d want 4 2 3", st_hi, rd_lo, cs_lo);
    end
    $display("single read: data=%h stall=%0d", bus_data_read, st_hi);
  endtask

  task automatic test_word_write();
    @(negedge clk);
    write_op = 1'b1; bus_size = 1'b1; bus_data_addr = 32'h4; bus_data_write = 32'h1122_3344;
    exp_q.push_back(32'h44); exp_q.push_back(32'h33); exp_q.push_back(32'h22); exp_q.push_back(32'h11);
    observe(20, 1'b0, 1'b1, 8'h00);
    checks++;
    if (st_hi !== 16 || wr_lo !== 8 || err_hi !== 0) begin
      errors++; $display("FAIL wrw_timing got stall=%0d wr=%0d err=%0d want 16 8 0", st_hi, wr_lo, err_hi);
    end
    checks++;
    if (addr_bad !== 0) begin errors++; $display("FAIL wrw_addr got bad=%0d want 0", addr_bad); end
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL wrw_beats got %0d want 4", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL wrw_lane got %h want %h", g, e); end
    end
    exp_q.delete();
    $display("word write: stall=%0d beats checked", st_hi);
  endtask

  task automatic test_word_read();
    logic [31:0] e;
    @(negedge clk);
    read_op = 1'b1; bus_size = 1'b1; bus_data_addr = 32'h0;
    rd_vals = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back(32'hEFBE_ADDE);
    observe(20, 1'b0, 1'b0, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (bus_data_read !== e || st_hi !== 16) begin
      errors++; $display("FAIL rdw_data got %h stall=%0d want %h 16", bus_data_read, st_hi, e);
    end
    $display("word read: data=%h", bus_data_read);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    write_op = 1'b1; bus_size = 1'b0; bus_data_addr = 32'h0; bus_data_write = 32'h0000_005A;
    exp_q.push_back(32'h5A); exp_q.push_back(32'h5A);
    observe(8, 1'b1, 1'b0, 8'h00);
    write_op = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== 2 || wr_lo !== 4) begin
      errors++; $display("FAIL b2b_count got beats=%0d wr=%0d want 2 4", got_q.size(), wr_lo);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_data got %h want %h", g, e); end
    end
    exp_q.delete();
    checks++;
    if (bus_stall !== 1'b0) begin errors++; $display("FAIL b2b_idle got stall=%b want 0", bus_stall); end
    $display("back-to-back: two writes observed with request held");
  endtask

`ifdef EXT_BUS_READY_EN
  task automatic test_timeout();
    @(negedge clk);
    ext_ready_n = 1'b1;
    read_op = 1'b1; bus_size = 1'b1; bus_data_addr = 32'h0;
    rd_vals = '{8'h77, 8'h66, 8'h55, 8'h44};
    exp_q.push_back(32'h0);
    observe(20, 1'b0, 1'b0, 8'h00);
    ext_ready_n = 1'b0;
    checks++;
    if (rd_lo !== 10 || err_hi !== 1 || st_hi !== 12) begin
      errors++; $display("FAIL tout_timing got rd=%0d err=%0d stall=%0d want 10 1 12", rd_lo, err_hi, st_hi);
    end
    checks++;
    if (bus_data_read !== exp_q[0]) begin
      errors++; $display("FAIL tout_data got %h want %h", bus_data_read, exp_q[0]);
    end
    void'(exp_q.pop_front());
    $display("timeout: strobe=%0d error pulses=%0d", rd_lo, err_hi);
  endtask
`endif

  task automatic test_abort();
    int rises, wr_seen, n;
    logic prev_rd;
    @(negedge clk);
    read_op = 1'b1; write_op = 1'b1; bus_size = 1'b1; bus_data_addr = 32'h0;
    bus_data_write = 32'hCAFE_F00D;
    rd_vals = '{8'h01, 8'h02, 8'h03, 8'h04};
    periph_d = rd_vals[0]; rd_idx = 0;
    @(posedge clk); #1;
    read_op = 1'b0; write_op = 1'b0;
    rises = 0; wr_seen = 0; n = 0; prev_rd = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!ext_wr_n) wr_seen++;
      if (ext_rd_n && !prev_rd) begin
        rises++; rd_idx++;
        periph_d = (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : '0;
      end
      prev_rd = ext_rd_n;
      if (rises == 2 && !ext_rd_n) break;
    end
    checks++;
    if (rises !== 2 || wr_seen !== 0) begin
      errors++; $display("FAIL abort_prio got rd_beats=%0d wr_cycles=%0d want 2 0", rises, wr_seen);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ext_cs_n !== 1'b1 || ext_rd_n !== 1'b1 || ext_wr_n !== 1'b1 || ext_rst_n !== 1'b0 ||
        bus_stall !== 1'b1 || bus_data_read !== 32'h0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got cs%b rd%b wr%b rstn%b stall%b rdata%h err%b want 1 1 1 0 1 0 0",
               ext_cs_n, ext_rd_n, ext_wr_n, ext_rst_n, bus_stall, bus_data_read, bus_error);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 40 && !ext_rst_n) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 16 || bus_stall !== 1'b0) begin
      errors++; $display("FAIL abort_recover got cycles=%0d stall=%b want 16 0", n, bus_stall);
    end
    $display("abort: reset mid-beat-2, recovered after %0d cycles", n);
  endtask

  task automatic test_irq();
    @(negedge clk);
    ext_intrq = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lat1 got %b want 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_lat2 got %b want 1", irq); end
    ext_intrq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b want 0", irq); end
    $display("irq: two-cycle synchroniser latency checked");
  endtask

  initial begin
    rst = 1'b1; read_op = 1'b0; write_op = 1'b0; bus_size = 1'b0;
    bus_data_addr = '0; bus_data_write = '0; ext_intrq = 1'b0; ext_ready_n = 1'b0;
    periph_d = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_write_single();
    test_read_single();
    test_word_write();
    test_word_read();
`ifdef EXT_BUS_READY_EN
    test_timeout();
`endif
    test_back_to_back();
    test_abort();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ext_async_bus_ctrl.md
Name: ext_async_bus_ctrl

Overview:
- Parametrised controller that bridges the CPU data bus to an 8- or 16-bit asynchronous external peripheral bus (SL811 USB, DM9000 Ethernet class parts).
- Adds programmable setup, strobe and hold timing.
- Packs a 32-bit word access into multiple external beats.
- Generates the peripheral power-on reset pulse and synchronises the interrupt line.

Parameters:
- DATA_W, 8, external data width; legal values 8 or 16.
- ADDR_W, 1, external address width; ext_addr = bus_data_addr[ADDR_W+1:2].
- SETUP_CYC, 1, cycles cs_n is low before the strobe falls; legal range 0..15.
- STROBE_CYC, 2, cycles rd_n/wr_n is held low; legal range 1..15.
- HOLD_CYC, 1, cycles after the strobe rises, with write data still driven; legal range 1..15.
- RST_CYC, 16, length in cycles of the ext_rst_n low pulse after rst releases; 0 disables the pulse.
- TIMEOUT_CYC, 255, maximum ready-wait cycles (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- read_op  in  1  read request, sampled in IDLE
- write_op  in  1  write request, sampled in IDLE
- bus_size  in  1  0 = single beat, 1 = full word (NB = 32/DATA_W beats)
- bus_data_addr  in  32  CPU byte address
- bus_data_write  in  32  write data
- bus_data_read  out  32  read data, registered
- bus_stall  out  1  CPU hold, registered
- bus_error  out  1  one-cycle pulse on ready timeout
- irq  out  1  synchronised ext_intrq
- ext_addr  out  ADDR_W  external address
- ext_d  inout  DATA_W  external data bus; high-Z unless driving a write
- ext_cs_n, ext_rd_n, ext_wr_n  out  1 each  active-low chip select and strobes
- ext_rst_n  out  1  active-low peripheral reset
- ext_intrq  in  1  peripheral interrupt, active-high, asynchronous
- ext_ready_n  in  1  peripheral not-ready, active-low ready (optional feature only)

Behaviour:
- Reset values (while rst high):
  - state = IDLE.
  - cs_n, rd_n, wr_n = 1; ext_d high-Z; bus_data_read = 0; bus_error = 0; irq = 0; beat counter = 0.
  - ext_rst_n = 0 and bus_stall = 1, with the reset counter loaded to RST_CYC.
  - If RST_CYC = 0: ext_rst_n = 1 and bus_stall = 0 instead.
- Post-reset pulse:
  - The reset counter decrements once per cycle after rst falls.
  - On the edge where it reaches 0: ext_rst_n goes to 1 and bus_stall goes to 0.
  - Requests are ignored until then.
- Request acceptance:
  - Only in IDLE with the reset counter at 0; read_op has priority over write_op.
  - On the accept edge: ext_addr is latched; bus_stall goes to 1; beat = 0; cs_n goes low.
  - For writes, ext_d drives lane 0 of bus_data_write.
  - Next state is SETUP, or STROBE if SETUP_CYC = 0. When entering STROBE, rd_n or wr_n goes low on the same edge.
- SETUP: lasts SETUP_CYC cycles, then STROBE; the strobe falls on the transition edge.
- STROBE: lasts STROBE_CYC cycles. At the exit edge:
  - rd_n, wr_n and cs_n go high.
  - For reads, ext_d is captured into lane[beat] of bus_data_read.
  - Next state is HOLD.
- HOLD: lasts HOLD_CYC cycles. At the exit edge:
  - If beat < NB-1 and bus_size = 1: beat increments, cs_n goes low, ext_d drives the next lane on writes, and the FSM returns to SETUP (or STROBE).
  - Otherwise: ext_d is released, bus_stall goes to 0, and the FSM returns to IDLE.
- Lanes: little-endian; lane k = bits [k*DATA_W +: DATA_W].
  - Every beat of a burst uses the same ext_addr (data-port semantics).
  - A single-beat read replicates the captured value across all 32 bits. For DATA_W = 8 that is {4{d}}.
- Latency: bus_stall is high for beats*(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles. Defaults give 4 cycles per beat.
- Request levels are ignored while the FSM is not in IDLE. A request held high after stall drops is accepted again on the next IDLE edge; the CPU must drop the request.
- rst asserted mid-access aborts immediately to the reset values, with no completion pulse.
- irq is a two-flop synchroniser, giving 2-cycle latency.

Optional Feature:
- Macro: EXT_BUS_READY_EN.
- Enabled:
  - After STROBE_CYC cycles, STROBE is extended while ext_ready_n = 1, for up to TIMEOUT_CYC extra cycles.
  - If still not ready at that point, the beat ends normally: strobe high, read lane captured as 0.
  - All remaining beats are skipped; bus_stall drops and bus_error pulses high for 1 cycle on the same edge.
- Disabled: ext_ready_n is ignored and bus_error is tied to 0.

Test Plan:
- Reset release, RST_CYC = 16 -> ext_rst_n low and bus_stall high for exactly 16 cycles after rst falls; a read_op issued during that window is ignored.
- Single-beat write, addr 0x4, data 0x000000A5 -> ext_addr = 1; cs_n low 3 cycles with wr_n low 2 of them; ext_d = 0xA5 for 4 cycles; bus_stall high 4 cycles.
- Single-beat read, addr 0x0, ext_d = 0x3C at the strobe-exit edge -> bus_data_read = 0x3C3C3C3C; bus_stall high 4 cycles.
- Word write, DATA_W = 8, data 0x11223344 -> 4 beats driving 0x44, 0x33, 0x22, 0x11 at a constant ext_addr; bus_stall high 16 cycles.
- Simultaneous read_op and write_op, plus rst asserted during beat 2 of a word read -> read is performed; rst returns all outputs to reset values on the asynchronous edge.
- EXT_BUS_READY_EN, TIMEOUT_CYC = 8, ext_ready_n stuck high on a word read -> beat 0 strobe lasts 10 cycles; bus_error pulses once; remaining beats are skipped; bus_data_read = 0.
